dcs_line_packet_tx: RTL and testbench

//  Command-mode DSI transmit framer: reads pre-packed RGB888 line words from a source FIFO and

---
 rtl/dcs_line_packet_tx_pkg.sv | 24 ++
 rtl/dcs_line_packet_tx_if.sv | 38 +++
 rtl/dcs_line_packet_tx_realign.sv | 39 +++
 rtl/dcs_line_packet_tx.sv | 163 ++++++++++++++++
 tb/tb_dcs_line_packet_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcs_line_packet_tx_pkg.sv
// Shared constants, FSM state type and byte-count helper for the DCS line packet framer.
package dcs_line_packet_tx_pkg;

    localparam logic [5:0] DT_DCS_LONG = 6'h39;
    localparam logic [7:0] DCS_WMS     = 8'h2C;
    localparam logic [7:0] DCS_WMC     = 8'h3C;
    localparam logic [1:0] VC_DEFAULT  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TE,
        ST_WAIT_LINE,
        ST_REQ,
        ST_PRIME,
        ST_PAYLOAD,
        ST_DONE
    } tx_state_e;

    // Long-packet byte count: three bytes per pixel plus the DCS command byte.
    function automatic logic [15:0] dcs_byte_count(input int unsigned x_res);
        return 16'(x_res * 3 + 1);
    endfunction

endpackage

// File: rtl/dcs_line_packet_tx_if.sv
// Host TX controller packet interface: header request/ack plus payload word stream.
interface dcs_line_packet_tx_if;

    logic        host_tx_cmd_req;
    logic [1:0]  host_tx_cmd_vc;
    logic [5:0]  host_tx_cmd_data_type;
    logic [15:0] host_tx_cmd_byte_count;
    logic        host_tx_hs_mode;
    logic [31:0] host_tx_payload;
    logic        host_tx_cmd_ack;
    logic        host_tx_payload_en;
    logic        host_tx_payload_en_last;

    modport master (
        output host_tx_cmd_req,
        output host_tx_cmd_vc,
        output host_tx_cmd_data_type,
        output host_tx_cmd_byte_count,
        output host_tx_hs_mode,
        output host_tx_payload,
        input  host_tx_cmd_ack,
        input  host_tx_payload_en,
        input  host_tx_payload_en_last
    );

    modport slave (
        input  host_tx_cmd_req,
        input  host_tx_cmd_vc,
        input  host_tx_cmd_data_type,
        input  host_tx_cmd_byte_count,
        input  host_tx_hs_mode,
        input  host_tx_payload,
        output host_tx_cmd_ack,
        output host_tx_payload_en,
        output host_tx_payload_en_last
    );

endinterface

// File: rtl/dcs_line_packet_tx_realign.sv
// One-byte realigner: shifts the line's word stream up by one byte behind the DCS command byte.
module dcs_byte_realign (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_first_i,
    input  logic        advance_i,
    input  logic        pad_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_word_i,
    input  logic [7:0]  dcs_i,
    output logic [31:0] payload_o
);

    logic [31:0] payload_q;
    logic [31:0] nxt_q;
    logic [7:0]  hi_q;
    logic [31:0] nxt_w;

    // A word arriving in the same cycle it is needed bypasses the hold register.
    assign nxt_w     = in_valid_i ? in_word_i : nxt_q;
    assign payload_o = payload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            nxt_q     <= '0;
            hi_q      <= '0;
        end else if (load_first_i) begin
            payload_q <= {in_word_i[23:0], dcs_i};
            hi_q      <= in_word_i[31:24];
        end else if (advance_i) begin
            payload_q <= pad_i ? {24'h0, hi_q} : {nxt_w[23:0], hi_q};
            hi_q      <= nxt_w[31:24];
        end else if (in_valid_i) begin
            nxt_q <= in_word_i;
        end
    end

endmodule

// File: rtl/dcs_line_packet_tx.sv
// Command-mode DSI line framer: one DCS long write per line from the tx line FIFO.
// Optional build macro TEAR_SYNC_EN gates the first line of each frame on a te rising edge.
module dcs_line_packet_tx
    import dcs_line_packet_tx_pkg::*;
#(
    parameter int TX_X_RESOLUTION = 1080,
    parameter int TX_Y_RESOLUTION = 2160
) (
    input  logic                        clktx,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic                        te,
    input  logic                        line_ready,
    input  logic [31:0]                 src_rdata,
    input  logic                        src_empty,
    output logic                        src_ren,
    dcs_line_packet_tx_if.master        host,
    output logic                        frame_busy,
    output logic                        frame_done,
    output logic                        underrun
);

    localparam int IN_WORDS  = TX_X_RESOLUTION * 3 / 4;
    localparam int OUT_WORDS = IN_WORDS + 1;
    localparam logic [11:0] LAST_WORD = 12'(OUT_WORDS - 1);
    localparam logic [11:0] LAST_IN   = 12'(IN_WORDS - 1);
    localparam logic [11:0] IN_CNT    = 12'(IN_WORDS);
    localparam logic [11:0] LAST_LINE = 12'(TX_Y_RESOLUTION - 1);

    tx_state_e   state_q, state_d;
    logic [11:0] line_q, line_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic [11:0] rdcnt_q, rdcnt_d;
    logic        prime_q, prime_d;
    logic        underrun_q, underrun_d;
    logic        rd_pend_q, emp_pend_q;
    logic        load_first, advance, pad, te_go;
    logic [31:0] in_word;

`ifdef TEAR_SYNC_EN
    logic [2:0] te_sync_q;

    always_ff @(posedge clktx or negedge rst_n) begin
        if (!rst_n) te_sync_q <= '0;
        else        te_sync_q <= {te_sync_q[1:0], te};
    end

    assign te_go = te_sync_q[1] & ~te_sync_q[2];
`else
    logic unused_te;
    assign unused_te = te;
    assign te_go     = 1'b1;
`endif

    always_ff @(posedge clktx or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            wcnt_q     <= '0;
            rdcnt_q    <= '0;
            prime_q    <= 1'b0;
            underrun_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            emp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            wcnt_q     <= wcnt_d;
            rdcnt_q    <= rdcnt_d;
            prime_q    <= prime_d;
            underrun_q <= underrun_d;
            rd_pend_q  <= src_ren;
            emp_pend_q <= src_ren & src_empty;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        wcnt_d     = wcnt_q;
        rdcnt_d    = rdcnt_q;
        prime_d    = prime_q;
        underrun_d = underrun_q;
        src_ren    = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_WAIT_TE;
                    line_d     = '0;
                    underrun_d = 1'b0;
                end
            end
            ST_WAIT_TE:   if (te_go) state_d = ST_WAIT_LINE;
            ST_WAIT_LINE: if (line_ready) state_d = ST_REQ;
            ST_REQ: begin
                if (host.host_tx_cmd_ack) begin
                    state_d = ST_PRIME;
                    prime_d = 1'b0;
                    wcnt_d  = '0;
                    rdcnt_d = '0;
                end
            end
            ST_PRIME: begin
                src_ren = 1'b1;
                rdcnt_d = rdcnt_q + 12'd1;
                prime_d = 1'b1;
                if (prime_q) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                // A short packet leaves unread words in the FIFO; they are not drained here.
                if (host.host_tx_payload_en_last) begin
                    if (wcnt_q != LAST_WORD) begin
                        underrun_d = 1'b1;
                        state_d    = ST_WAIT_LINE;
                    end else if (line_q == LAST_LINE) begin
                        state_d = ST_DONE;
                    end else begin
                        line_d  = line_q + 12'd1;
                        state_d = ST_WAIT_LINE;
                    end
                end else if (host.host_tx_payload_en && wcnt_q != LAST_WORD) begin
                    advance = 1'b1;
                    wcnt_d  = wcnt_q + 12'd1;
                    if (rdcnt_q < IN_CNT) begin
                        src_ren = 1'b1;
                        rdcnt_d = rdcnt_q + 12'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (src_ren && src_empty) underrun_d = 1'b1;
    end

    assign load_first = (state_q == ST_PRIME) && prime_q;
    assign pad        = (wcnt_q == LAST_IN);
    assign in_word    = emp_pend_q ? '0 : src_rdata;

    dcs_byte_realign u_realign (
        .clk          (clktx),
        .rst_n        (rst_n),
        .load_first_i (load_first),
        .advance_i    (advance),
        .pad_i        (pad),
        .in_valid_i   (rd_pend_q),
        .in_word_i    (in_word),
        .dcs_i        ((line_q == '0) ? DCS_WMS : DCS_WMC),
        .payload_o    (host.host_tx_payload)
    );

    assign host.host_tx_cmd_req        = (state_q == ST_REQ);
    assign host.host_tx_cmd_vc         = VC_DEFAULT;
    assign host.host_tx_cmd_data_type  = DT_DCS_LONG;
    assign host.host_tx_cmd_byte_count = dcs_byte_count(TX_X_RESOLUTION);
    assign host.host_tx_hs_mode        = 1'b1;

    assign frame_busy = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dcs_line_packet_tx.sv
// Bench for dcs_line_packet_tx at X=8, Y=2: byte-stream reference model, FIFO and host models.
module tb_dcs_line_packet_tx;

    localparam int X     = 8;
    localparam int Y     = 2;
    localparam int IN_W  = 6;
    localparam int OUT_W = 7;

    logic        clktx = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        te = 1'b0;
    logic        line_ready = 1'b0;
    logic [31:0] src_rdata;
    logic        src_empty;
    logic        src_ren;
    logic        frame_busy, frame_done, underrun;

    dcs_line_packet_tx_if hif ();

    dcs_line_packet_tx #(.TX_X_RESOLUTION(X), .TX_Y_RESOLUTION(Y)) dut (
        .clktx       (clktx),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .te          (te),
        .line_ready  (line_ready),
        .src_rdata   (src_rdata),
        .src_empty   (src_empty),
        .src_ren     (src_ren),
        .host        (hif),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clktx = ~clktx;

    // Source FIFO model; empty_at forces an empty flag at one read index of the current line.
    logic [31:0] fmem [0:255];
    int unsigned wp = 0, rp = 0;
    int total_reads = 0, line_base = 0, empty_at = -1;

    assign src_empty = (wp == rp) || ((total_reads - line_base) == empty_at);

    always @(posedge clktx) begin
        if (src_ren) begin
            if (!src_empty) begin
                src_rdata <= fmem[rp[7:0]];
                rp        <= rp + 1;
            end else begin
                src_rdata <= 32'hDEADBEEF;
            end
            total_reads <= total_reads + 1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [31:0] cur_in  [IN_W];
    logic [31:0] exp_out [OUT_W];
    logic [31:0] got     [OUT_W];

    typedef struct {
        logic [7:0]  base;
        logic [31:0] e0, e1, e6;
    } vec_t;
    vec_t tbl [6];

    task automatic tick();
        @(negedge clktx);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference: the packet payload is the byte stream [DCS, pixel bytes...] zero-padded to whole words.
    function automatic void build_exp(input int line);
        logic [7:0] bytes [OUT_W*4];
        for (int b = 0; b < OUT_W*4; b++) bytes[b] = 8'h00;
        bytes[0] = (line == 0) ? 8'h2C : 8'h3C;
        for (int i = 0; i < IN_W; i++)
            for (int j = 0; j < 4; j++)
                bytes[1 + 4*i + j] = cur_in[i][8*j +: 8];
        for (int k = 0; k < OUT_W; k++)
            exp_out[k] = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
    endfunction

    function automatic void fill_bytes(input logic [7:0] base);
        for (int i = 0; i < IN_W; i++)
            for (int j = 0; j < 4; j++)
                cur_in[i][8*j +: 8] = 8'(int'(base) + 4*i + j);
    endfunction

    function automatic void fill_rand();
        for (int i = 0; i < IN_W; i++) cur_in[i] = $urandom;
    endfunction

    // Pushes the line's words; the word at eidx is never pushed and the DUT must substitute zero.
    task automatic push_line(input int eidx);
        line_base = total_reads;
        empty_at  = eidx;
        for (int i = 0; i < IN_W; i++) begin
            if (i == eidx) cur_in[i] = '0;
            else begin
                fmem[wp[7:0]] = cur_in[i];
                wp = wp + 1;
            end
        end
    endtask

    task automatic wait_req(input string nm, input int budget);
        int t;
        t = 0;
        while (hif.host_tx_cmd_req !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
        check(nm, hif.host_tx_cmd_req, 1);
    endtask

    task automatic ack_header();
        check("byte_count", hif.host_tx_cmd_byte_count, 25);
        check("data_type", hif.host_tx_cmd_data_type, 6'h39);
        check("vc", hif.host_tx_cmd_vc, 0);
        check("hs_mode", hif.host_tx_hs_mode, 1);
        hif.host_tx_cmd_ack = 1'b1;
        tick();
        hif.host_tx_cmd_ack = 1'b0;
        check("req_drop", hif.host_tx_cmd_req, 0);
        repeat (3 + $urandom_range(0, 3)) tick();
    endtask

    task automatic do_line(input int line, input int gap_max, input int eidx, input bit last);
        push_line(eidx);
        build_exp(line);
        wait_req("req_rise", 400);
        ack_header();
        for (int k = 0; k < OUT_W; k++) begin
            got[k] = hif.host_tx_payload;
            check($sformatf("payload_l%0d_w%0d", line, k), hif.host_tx_payload, exp_out[k]);
            if (k < OUT_W-1) hif.host_tx_payload_en = 1'b1;
            else             hif.host_tx_payload_en_last = 1'b1;
            tick();
            hif.host_tx_payload_en      = 1'b0;
            hif.host_tx_payload_en_last = 1'b0;
            if (k < OUT_W-1) repeat ($urandom_range(0, gap_max)) tick();
        end
        check("line_reads", total_reads - line_base, IN_W);
        check("frame_done", frame_done, last);
        empty_at = -1;
    endtask

    task automatic start_frame();
        line_ready  = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("busy_on_start", frame_busy, 1);
        check("underrun_clr", underrun, 0);
`ifdef TEAR_SYNC_EN
        repeat (50) tick();
        check("te_wait_req", hif.host_tx_cmd_req, 0);
        te = 1'b1;
        repeat (3) begin
            tick();
            check("te_sync_req", hif.host_tx_cmd_req, 0);
        end
        tick();
        check("te_req", hif.host_tx_cmd_req, 1);
        te = 1'b0;
`else
        te = 1'($urandom);
`endif
    endtask

    task automatic end_frame();
        tick();
        check("done_pulse_end", frame_done, 0);
        check("busy_end", frame_busy, 0);
        te = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_req", hif.host_tx_cmd_req, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_payload", hif.host_tx_payload, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ren", src_ren, 0);
        rst_n = 1'b1;
        wp = rp;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_cnt, base_reads;

        tbl[0] = '{8'h00, 32'h0201002C, 32'h06050403, 32'h00000017};
        tbl[1] = '{8'h00, 32'h0201003C, 32'h06050403, 32'h00000017};
        tbl[2] = '{8'hA0, 32'hA2A1A02C, 32'hA6A5A4A3, 32'h000000B7};
        tbl[3] = '{8'h40, 32'h4241403C, 32'h46454443, 32'h00000057};
        tbl[4] = '{8'hF0, 32'hF2F1F02C, 32'hF6F5F4F3, 32'h00000007};
        tbl[5] = '{8'h10, 32'h1211103C, 32'h16151413, 32'h00000027};

        hif.host_tx_cmd_ack         = 1'b0;
        hif.host_tx_payload_en      = 1'b0;
        hif.host_tx_payload_en_last = 1'b0;

        repeat (3) tick();
        check("reset_req", hif.host_tx_cmd_req, 0);
        check("reset_payload", hif.host_tx_payload, 0);
        check("reset_busy", frame_busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_underrun", underrun, 0);
        check("reset_bc", hif.host_tx_cmd_byte_count, 25);
        check("reset_dt", hif.host_tx_cmd_data_type, 6'h39);
        check("reset_hs", hif.host_tx_hs_mode, 1);
        rst_n = 1'b1;
        tick();

        // Payload en outside a packet must not disturb the idle framer.
        hif.host_tx_payload_en = 1'b1;
        tick();
        hif.host_tx_payload_en = 1'b0;
        check("idle_en_payload", hif.host_tx_payload, 0);
        check("idle_en_ren", total_reads, 0);

        for (int f = 0; f < 3; f++) begin
            start_frame();
            for (int l = 0; l < Y; l++) begin
                fill_bytes(tbl[2*f+l].base);
                do_line(l, 2, -1, l == Y-1);
                check($sformatf("tbl%0d_w0", 2*f+l), got[0], tbl[2*f+l].e0);
                check($sformatf("tbl%0d_w1", 2*f+l), got[1], tbl[2*f+l].e1);
                check($sformatf("tbl%0d_w6", 2*f+l), got[6], tbl[2*f+l].e6);
            end
            end_frame();
        end

        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int l = 0; l < Y; l++) begin
                if (l > 0 && $urandom_range(0, 1) == 1) begin
                    line_ready = 1'b0;
                    repeat ($urandom_range(1, 10)) tick();
                    line_ready = 1'b1;
                end
                fill_rand();
                do_line(l, 3, -1, l == Y-1);
            end
            end_frame();
        end

        // Line gap: with line_ready low the framer must neither request nor read.
        start_frame();
        fill_rand();
        do_line(0, 1, -1, 1'b0);
        line_ready = 1'b0;
        hold_cnt   = 0;
        base_reads = total_reads;
        repeat (100) begin
            tick();
            if (hif.host_tx_cmd_req === 1'b1 || src_ren === 1'b1) hold_cnt++;
        end
        check("gap_req_or_ren", hold_cnt, 0);
        check("gap_reads", total_reads - base_reads, 0);
        line_ready = 1'b1;
        fill_rand();
        do_line(1, 1, -1, 1'b1);
        end_frame();

        // FIFO empty at word 3: zero substituted, underrun sticky, frame still completes.
        start_frame();
        fill_rand();
        do_line(0, 2, 3, 1'b0);
        check("empty_underrun", underrun, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ignored_start_underrun", underrun, 1);
        fill_rand();
        do_line(1, 2, -1, 1'b1);
        check("empty_underrun_hold", underrun, 1);
        end_frame();

        // Early en_last: line aborted, underrun set, framer waits for the next line.
        start_frame();
        fill_rand();
        do_line(0, 1, -1, 1'b0);
        fill_rand();
        push_line(-1);
        wait_req("abort_req", 400);
        ack_header();
        repeat (3) begin
            hif.host_tx_payload_en = 1'b1;
            tick();
            hif.host_tx_payload_en = 1'b0;
        end
        hif.host_tx_payload_en_last = 1'b1;
        tick();
        hif.host_tx_payload_en_last = 1'b0;
        check("abort_underrun", underrun, 1);
        check("abort_no_done", frame_done, 0);
        check("abort_busy", frame_busy, 1);
        wait_req("abort_rereq", 50);
        do_reset();

        // Reset while word 4 of a payload is presented; the next frame must run clean.
        start_frame();
        fill_rand();
        push_line(-1);
        build_exp(0);
        wait_req("mid_req", 400);
        ack_header();
        for (int k = 0; k < 4; k++) begin
            hif.host_tx_payload_en = 1'b1;
            tick();
            hif.host_tx_payload_en = 1'b0;
        end
        check("mid_word4", hif.host_tx_payload, exp_out[4]);
        do_reset();
        start_frame();
        for (int l = 0; l < Y; l++) begin
            fill_rand();
            do_line(l, 2, -1, l == Y-1);
        end
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
